// File: rtl/riscv_program_loader_if.sv
// Instruction-memory write port used by the boot loader to fill program memory.
interface riscv_program_loader_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/riscv_program_loader.sv
// Boot-time loader: writes a fixed 8-word RV32I test program (built from the
// operand/ALU-select inputs) into instruction memory, then raises a sticky done.
module riscv_program_loader #(
  parameter int         PROG_WORDS = 8,
  parameter logic [4:0] MEM_ADDR   = 5'd4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             op1,
  input  logic [11:0]             op2,
  input  logic [2:0]              alu_op,
  riscv_program_loader_if.master  imem,
  output logic                    done
);

  localparam int IDX_W = $clog2(PROG_WORDS) + 1;

  typedef enum logic {LOAD, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic             cap_vld;
  logic [11:0]      op1_q, op2_q;
  logic [2:0]       alu_op_q;
  logic [11:0]      op1_eff, op2_eff;
  logic [2:0]       alu_op_eff;

  function automatic logic [9:0] alu_funct(input logic [2:0] sel);
    case (sel)
      3'b000:  alu_funct = {7'h00, 3'b000};
      3'b001:  alu_funct = {7'h20, 3'b000};
      3'b010:  alu_funct = {7'h00, 3'b111};
      3'b011:  alu_funct = {7'h00, 3'b110};
      3'b100:  alu_funct = {7'h00, 3'b100};
      3'b101:  alu_funct = {7'h00, 3'b010};
      3'b110:  alu_funct = {7'h00, 3'b001};
      default: alu_funct = {7'h00, 3'b101};
    endcase
  endfunction

  function automatic logic [31:0] prog_word(input logic [2:0]  idx,
                                            input logic [11:0] a,
                                            input logic [11:0] b,
                                            input logic [2:0]  sel);
    logic [9:0] f;
    f = alu_funct(sel);
    case (idx)
      3'd0:    prog_word = {a, 5'd0, 3'b000, 5'd9, 7'h13};
      3'd1:    prog_word = {b, 5'd0, 3'b000, 5'd10, 7'h13};
      3'd2:    prog_word = {f[9:3], 5'd10, 5'd9, f[2:0], 5'd11, 7'h33};
      3'd3:    prog_word = {7'd0, 5'd11, 5'd0, 3'b010, MEM_ADDR, 7'h23};
      3'd4:    prog_word = {7'd0, MEM_ADDR, 5'd0, 3'b010, 5'd12, 7'h03};
      3'd5,
      3'd6:    prog_word = 32'h0000_0013;
      default: prog_word = 32'h0000_006F;
    endcase
  endfunction

  // Word 0 is emitted on the same edge that captures the operands, so the
  // live inputs are used until the capture flag is set.
  always_comb begin
    op1_eff    = cap_vld ? op1_q    : op1;
    op2_eff    = cap_vld ? op2_q    : op2;
    alu_op_eff = cap_vld ? alu_op_q : alu_op;
  end

  always_ff @(posedge clk) begin
    if (!cap_vld) begin
      op1_q    <= op1;
      op2_q    <= op2;
      alu_op_q <= alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= LOAD;
      index           <= '0;
      cap_vld         <= 1'b0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
      done            <= 1'b0;
    end else begin
      cap_vld <= 1'b1;
      case (state)
        LOAD: begin
          if (index == IDX_W'(PROG_WORDS)) begin
            imem.imem_we <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            imem.imem_we    <= 1'b1;
            imem.imem_addr  <= {{(30-IDX_W){1'b0}}, index, 2'b00};
            imem.imem_wdata <= prog_word(index[2:0], op1_eff, op2_eff, alu_op_eff);
            index           <= index + 1'b1;
          end
        end
        default: begin
          imem.imem_we <= 1'b0;
          done         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_program_loader.sv
// Directed bench for the boot loader: program contents, ALU encodings, operand
// capture, sticky done, and reset during load and after completion.
module tb_riscv_program_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] op1 = '0;
  logic [11:0] op2 = '0;
  logic [2:0]  alu_op = '0;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [8];

  riscv_program_loader_if bus();

  riscv_program_loader dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .alu_op (alu_op),
    .imem   (bus),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  task automatic set_base();
    exp_w = '{32'h00A00493, 32'h00800513, 32'h00A485B3, 32'h00B02223,
              32'h00402603, 32'h00000013, 32'h00000013, 32'h0000006F};
  endtask

  task automatic start(input logic [11:0] a, input logic [11:0] b, input logic [2:0] sel);
    @(negedge clk);
    rst    = 1'b0;
    op1    = a;
    op2    = b;
    alu_op = sel;
    repeat (2) @(negedge clk);
    chk("rst_we",    {31'd0, bus.imem_we}, 32'd0);
    chk("rst_addr",  bus.imem_addr,        32'd0);
    chk("rst_wdata", bus.imem_wdata,       32'd0);
    chk("rst_done",  {31'd0, done},        32'd0);
    rst = 1'b1;
  endtask

  task automatic load_words(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("we_%0d", i),    {31'd0, bus.imem_we}, 32'd1);
      chk($sformatf("addr_%0d", i),  bus.imem_addr,        32'(i * 4));
      chk($sformatf("wdata_%0d", i), bus.imem_wdata,       exp_w[i]);
      chk($sformatf("ndone_%0d", i), {31'd0, done},        32'd0);
      if (poke && i == 0) op1 = 12'd5;
    end
  endtask

  task automatic finish_check();
    @(posedge clk);
    #1;
    chk("fin_we",    {31'd0, bus.imem_we}, 32'd0);
    chk("fin_done",  {31'd0, done},        32'd1);
    chk("fin_addr",  bus.imem_addr,        32'h1C);
    chk("fin_wdata", bus.imem_wdata,       32'h0000006F);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    // Base program, op1 changed after capture, sticky done, reset in DONE
    set_base();
    start(12'd10, 12'd8, 3'b000);
    load_words(8, 1'b1);
    finish_check();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold_we",   {31'd0, bus.imem_we}, 32'd0);
      chk("hold_done", {31'd0, done},        32'd1);
    end
    rst = 1'b0;
    #1;
    chk("rstdone_done", {31'd0, done},        32'd0);
    chk("rstdone_we",   {31'd0, bus.imem_we}, 32'd0);

    set_base();
    exp_w[2] = 32'h40A485B3;
    start(12'd10, 12'd8, 3'b001);
    load_words(8, 1'b0);
    finish_check();

    set_base();
    exp_w[2] = 32'h00A4F5B3;
    start(12'd10, 12'd8, 3'b010);
    load_words(8, 1'b0);
    finish_check();

    set_base();
    exp_w[0] = 32'hFFF00493;
    start(12'hFFF, 12'd8, 3'b000);
    load_words(8, 1'b0);
    finish_check();

    // Reset after three writes, then reload with a new ALU select
    set_base();
    start(12'd10, 12'd8, 3'b000);
    load_words(3, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_we",   {31'd0, bus.imem_we}, 32'd0);
    chk("mid_done", {31'd0, done},        32'd0);
    chk("mid_addr", bus.imem_addr,        32'd0);
    exp_w[2] = 32'h00A4F5B3;
    start(12'd10, 12'd8, 3'b010);
    load_words(8, 1'b0);
    finish_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
